// File: rtl/xyolo_write_pkg.sv
// Shared constants, FSM state encoding and packing helper for the YOLO output writer.
package xyolo_write_pkg;

  localparam int unsigned XYOLO_WR_RES_W = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2,
    StFin     = 2'd3
  } xyolo_wr_state_e;

  // The earlier result occupies the low half of the packed word.
  function automatic logic [2*XYOLO_WR_RES_W-1:0] pack_pair(
    input logic [XYOLO_WR_RES_W-1:0] hi,
    input logic [XYOLO_WR_RES_W-1:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/xyolo_write_fifo.sv
// Synchronous show-ahead FIFO, depth 2**AW. A push on a full FIFO is accepted
// only when a pop frees the head slot in the same cycle.
module xyolo_write_fifo #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          wr_en, rd_en;

  always_comb begin
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    level  = wptr_q - rptr_q;
    rd_en  = pop && !empty;
    wr_en  = push && (!full || rd_en);
    wptr_d = wptr_q + {{AW{1'b0}}, wr_en};
    rptr_d = rptr_q + {{AW{1'b0}}, rd_en};
    rdata  = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/xyolo_write.sv
// YOLO FU output writer: narrows results to 16 bits, packs two per word and drains them
// to the memory write port. Define XYOLO_WRITE_SAT_EN to saturate instead of truncate.
module xyolo_write
  import xyolo_write_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       nres,
  input  logic              in_en,
  input  logic [DATA_W-1:0] flow_in,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int unsigned RW = XYOLO_WR_RES_W;

  xyolo_wr_state_e   state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [15:0]       nres_q, nres_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [RW-1:0]     low_q, low_d;
  logic              ovf_q, ovf_d;

  logic [RW-1:0]     res_val;
  logic [2*RW-1:0]   pair;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_wdata, fifo_rdata;
  logic [FIFO_AW:0]  fifo_level;

`ifdef XYOLO_WRITE_SAT_EN
  localparam logic [DATA_W-1:0] SatMax = DATA_W'(32767);
  localparam logic [DATA_W-1:0] SatMin = ~SatMax;

  always_comb begin
    if ($signed(flow_in) > $signed(SatMax)) begin
      res_val = 16'h7FFF;
    end else if ($signed(flow_in) < $signed(SatMin)) begin
      res_val = 16'h8000;
    end else begin
      res_val = flow_in[RW-1:0];
    end
  end
`else
  logic unused_flow_hi;
  assign unused_flow_hi = ^flow_in[DATA_W-1:RW];

  always_comb begin
    res_val = flow_in[RW-1:0];
  end
`endif

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    wcnt_d    = wcnt_q;
    nres_d    = nres_q;
    cnt_d     = cnt_q;
    low_d     = low_q;
    ovf_d     = ovf_q;
    fifo_push = 1'b0;
    pair      = '0;
    fifo_pop  = !fifo_empty && m_ready;

    if (fifo_pop) begin
      wcnt_d = wcnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end

    unique case (state_q)
      StIdle: begin
        if (run) begin
          if (nres != 16'd0) begin
            base_d  = base;
            nres_d  = nres;
            cnt_d   = '0;
            low_d   = '0;
            ovf_d   = 1'b0;
            wcnt_d  = '0;
            state_d = StCollect;
          end else begin
            state_d = StFin;
          end
        end
      end
      StCollect: begin
        if (in_en) begin
          cnt_d = cnt_q + 16'd1;
          if (!cnt_q[0]) begin
            low_d = res_val;
            // Odd job length: the final lone result goes out with a zero high half.
            if (cnt_d == nres_q) begin
              fifo_push = 1'b1;
              pair      = pack_pair('0, res_val);
            end
          end else begin
            fifo_push = 1'b1;
            pair      = pack_pair(res_val, low_q);
          end
          if (cnt_d == nres_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave as the last word is accepted so done follows it by one cycle.
        if (fifo_empty || (fifo_pop && fifo_level == (FIFO_AW + 1)'(1))) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end

    fifo_wdata = DATA_W'(pair);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      wcnt_q  <= '0;
      nres_q  <= '0;
      cnt_q   <= '0;
      low_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wcnt_q  <= wcnt_d;
      nres_q  <= nres_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      ovf_q   <= ovf_d;
    end
  end

  xyolo_write_fifo #(
    .DW (DATA_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    m_valid = !fifo_empty;
    // Gate the head so unwritten storage never reaches the bus.
    m_wdata = fifo_empty ? '0 : fifo_rdata;
    m_addr  = base_q + wcnt_q;
    busy    = (state_q != StIdle);
    done    = (state_q == StFin);
    ovf     = ovf_q;
  end

endmodule

// File: tb/tb_xyolo_write.sv
// Scoreboard bench for xyolo_write: expected writes are queued from a reference model
// when a job is issued and a monitor pops and compares on each accepted transfer.
`timescale 1ns/1ps
module tb_xyolo_write;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned FIFO_AW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic [15:0]       nres = '0;
  logic              in_en = 1'b0;
  logic [DATA_W-1:0] flow_in = '0;
  logic              m_ready = 1'b0;
  logic              m_valid, busy, done, ovf;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  ncyc = 0;
  int  last_wr_cyc = 0;
  int  done_cyc = 0;
  bit  rnd_ready = 1'b0;

  always #5 clk = ~clk;

  xyolo_write #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .FIFO_AW (FIFO_AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .base    (base),
    .nres    (nres),
    .in_en   (in_en),
    .flow_in (flow_in),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Reference narrowing from the numeric rule, on a signed integer view of the result.
  function automatic logic [15:0] ref_narrow(input logic [31:0] v);
`ifdef XYOLO_WRITE_SAT_EN
    int s;
    s = int'(v);
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  // Job model: pair consecutive results, zero-fill an odd tail, keep what fits.
  task automatic expect_job(input logic [31:0] b, input logic [31:0] vals[$], input int keep);
    int nw;
    logic [15:0] lo, hi;
    wr_t w;
    nw = (vals.size() + 1) / 2;
    for (int i = 0; i < nw && i < keep; i++) begin
      lo = ref_narrow(vals[2*i]);
      hi = (2*i + 1 < vals.size()) ? ref_narrow(vals[2*i+1]) : 16'h0;
      w.addr = b + 32'(i);
      w.data = {hi, lo};
      exp_q.push_back(w);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] b, input logic [15:0] n);
    run = 1'b1;
    base = b;
    nres = n;
    cyc();
    run = 1'b0;
    base = $urandom;
    nres = 16'($urandom);
  endtask

  task automatic feed(input logic [31:0] vals[$], input int gap_max);
    foreach (vals[i]) begin
      repeat ($urandom_range(gap_max, 0)) begin
        flow_in = $urandom;
        cyc();
      end
      in_en = 1'b1;
      flow_in = vals[i];
      cyc();
      in_en = 1'b0;
    end
  endtask

  task automatic wait_done(input string name, input bit lat_check);
    int start, k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({name, "_done"}, 64'(done_cnt - start), 64'd1);
    if (lat_check) check({name, "_done_lat"}, 64'(done_cyc - last_wr_cyc), 64'd1);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    check({name, "_busy_fall"}, {63'd0, busy}, 64'd0);
    check({name, "_done_fall"}, {63'd0, done}, 64'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_m_valid"}, {63'd0, m_valid}, 64'd0);
    check({name, "_m_addr"}, 64'(m_addr), 64'd0);
    check({name, "_m_wdata"}, 64'(m_wdata), 64'd0);
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_done"}, {63'd0, done}, 64'd0);
    check({name, "_ovf"}, {63'd0, ovf}, 64'd0);
  endtask

  initial begin : rand_ready
    forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) m_ready = 1'($urandom_range(1, 0));
    end
  end

  initial begin : monitor
    wr_t e;
    bit stall;
    logic [31:0] st_addr, st_data;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", {63'd0, m_valid}, 64'd1);
          check("hold_addr", 64'(m_addr), 64'(st_addr));
          check("hold_data", 64'(m_wdata), 64'(st_data));
        end
        if (m_valid && m_ready) begin
          wr_cnt++;
          last_wr_cyc = ncyc;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got %0h@%0h, required no write", m_wdata, m_addr);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(m_addr), 64'(e.addr));
            check("wr_data", 64'(m_wdata), 64'(e.data));
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = ncyc;
        end
        stall = m_valid && !m_ready;
        st_addr = m_addr;
        st_data = m_wdata;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] vals[$];
    logic [31:0] part[$];
    logic [31:0] b;
    int w0, k, n;

    repeat (2) cyc();
    check_idle_outputs("reset");
    rst = 1'b0;
    cyc();

    // Even count, no backpressure; first word visible the cycle after its pair completes.
    m_ready = 1'b1;
    vals = '{32'd1, 32'd2, 32'd3, 32'd4};
    expect_job(32'h100, vals, 8);
    start_job(32'h100, 16'd4);
    check("run_busy", {63'd0, busy}, 64'd1);
    part = '{32'd1, 32'd2};
    feed(part, 0);
    check("pair_valid", {63'd0, m_valid}, 64'd1);
    check("pair_data", 64'(m_wdata), 64'h0002_0001);
    check("pair_addr", 64'(m_addr), 64'h100);
    part = '{32'd3, 32'd4};
    feed(part, 0);
    wait_done("even", 1'b1);
    check("even_ovf", {63'd0, ovf}, 64'd0);

    // Odd count.
    vals = '{32'd5, 32'd6, 32'd7};
    expect_job(32'h200, vals, 8);
    start_job(32'h200, 16'd3);
    feed(vals, 1);
    wait_done("odd", 1'b1);

    // Narrowing of out-of-range results.
    vals = '{32'd70000, -32'sd70000};
    expect_job(32'h280, vals, 8);
    start_job(32'h280, 16'd2);
    feed(vals, 0);
    wait_done("narrow", 1'b1);

    // Backpressure: 9 words offered to an 8-deep FIFO, the last is dropped.
    m_ready = 1'b0;
    vals.delete();
    for (int i = 1; i <= 18; i++) vals.push_back(32'(i));
    expect_job(32'h700, vals, 8);
    start_job(32'h700, 16'd18);
    feed(vals, 0);
    in_en = 1'b1;
    repeat (3) begin
      flow_in = $urandom;
      cyc();
    end
    in_en = 1'b0;
    check("bp_ovf", {63'd0, ovf}, 64'd1);
    check("bp_valid", {63'd0, m_valid}, 64'd1);
    check("bp_addr", 64'(m_addr), 64'h700);
    check("bp_data", 64'(m_wdata), 64'h0002_0001);
    check("bp_busy", {63'd0, busy}, 64'd1);
    w0 = wr_cnt;
    m_ready = 1'b1;
    wait_done("bp", 1'b1);
    check("bp_writes", 64'(wr_cnt - w0), 64'd8);

    // Push and pop together on a full FIFO: no drop.
    m_ready = 1'b0;
    vals.delete();
    part.delete();
    for (int i = 0; i < 18; i++) vals.push_back($urandom);
    for (int i = 0; i < 17; i++) part.push_back(vals[i]);
    expect_job(32'h800, vals, 9);
    start_job(32'h800, 16'd18);
    feed(part, 0);
    in_en = 1'b1;
    flow_in = vals[17];
    m_ready = 1'b1;
    cyc();
    in_en = 1'b0;
    wait_done("full_pp", 1'b1);
    check("full_pp_ovf", {63'd0, ovf}, 64'd0);

    // Reset mid-job after two of six writes.
    m_ready = 1'b0;
    vals.delete();
    for (int i = 0; i < 12; i++) vals.push_back($urandom);
    expect_job(32'h300, vals, 8);
    start_job(32'h300, 16'd12);
    feed(vals, 0);
    w0 = wr_cnt;
    m_ready = 1'b1;
    k = 0;
    while (wr_cnt < w0 + 2 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("rst_two_writes", 64'(wr_cnt - w0), 64'd2);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
    repeat (3) begin
      cyc();
      check("rst_no_partial", {63'd0, m_valid}, 64'd0);
    end

    // New job after reset; a second run while busy must be ignored.
    vals = '{32'hAAAA_1111, 32'h5555_2222};
    expect_job(32'h400, vals, 8);
    start_job(32'h400, 16'd2);
    run = 1'b1;
    base = 32'h500;
    nres = 16'd6;
    cyc();
    run = 1'b0;
    feed(vals, 1);
    wait_done("restart", 1'b1);

    // Zero count completes at once with no write.
    start_job(32'h600, 16'd0);
    check("zero_done", {63'd0, done}, 64'd1);
    check("zero_valid", {63'd0, m_valid}, 64'd0);
    cyc();
    check("zero_done_fall", {63'd0, done}, 64'd0);
    check("zero_busy_fall", {63'd0, busy}, 64'd0);

    // Randomized jobs small enough never to overflow, with random ready.
    rnd_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      b = $urandom;
      n = $urandom_range(16, 1);
      vals.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(3, 0))
          0: vals.push_back(32'($urandom_range(70000, 0)));
          1: vals.push_back(-32'($urandom_range(70000, 0)));
          default: vals.push_back($urandom);
        endcase
      end
      expect_job(b, vals, 8);
      start_job(b, 16'(n));
      feed(vals, 2);
      wait_done("rand", 1'b1);
      check("rand_ovf", {63'd0, ovf}, 64'd0);
    end
    rnd_ready = 1'b0;
    m_ready = 1'b1;
    repeat (4) cyc();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
